// File: rtl/flu_wb_merge_pkg.sv
// flu_wb_merge_pkg
// Shared constants and types for the fixed-latency writeback merge.
// Holds the default channel count and buffer depth, the result/ID widths,
// the per-entry record that travels through each channel buffer, and a
// helper that sizes channel-index fields.
package flu_wb_merge_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned FLU_WB_NR_CH  = 4;
    localparam int unsigned FLU_WB_DEPTH  = 2;

    typedef logic [XLEN-1:0] xlen_t;

    typedef struct packed {
        xlen_t                    result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic                     ex;
    } flu_wb_entry_t;

    // Width of a channel index; a single channel still gets a 1-bit field.
    function automatic int unsigned idxWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flu_wb_merge_if.sv
// flu_wb_merge_if
// Bundles the per-channel producer signals and the merged scoreboard write
// port of flu_wb_merge.
//   ch_valid_i / ch_ready_o       per-channel push handshake
//   ch_result_i / ch_trans_id_i   per-channel result payload and ID
//   ch_ex_i                       per-channel exception flag
//   wb_valid_o / wb_ready_i       merged writeback handshake
//   wb_result_o / wb_trans_id_o   merged payload and ID
//   wb_ex_o / wb_ch_o             merged exception flag, granted channel
// Modports: slave is the merge unit, master is the surrounding logic that
// drives the channels and consumes the writeback.
interface flu_wb_merge_if
    import flu_wb_merge_pkg::*;
#(
    parameter int unsigned NR_CH  = FLU_WB_NR_CH,
    parameter int unsigned DATA_W = XLEN,
    parameter int unsigned TID_W  = TRANS_ID_BITS
);
    localparam int unsigned CH_W = idxWidth(NR_CH);

    logic [NR_CH-1:0]             ch_valid_i;
    logic [NR_CH-1:0]             ch_ready_o;
    logic [NR_CH-1:0][DATA_W-1:0] ch_result_i;
    logic [NR_CH-1:0][TID_W-1:0]  ch_trans_id_i;
    logic [NR_CH-1:0]             ch_ex_i;

    logic                         wb_valid_o;
    logic                         wb_ready_i;
    logic [DATA_W-1:0]            wb_result_o;
    logic [TID_W-1:0]             wb_trans_id_o;
    logic                         wb_ex_o;
    logic [CH_W-1:0]              wb_ch_o;

    modport master (
        output ch_valid_i, ch_result_i, ch_trans_id_i, ch_ex_i, wb_ready_i,
        input  ch_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_o, wb_ch_o
    );

    modport slave (
        input  ch_valid_i, ch_result_i, ch_trans_id_i, ch_ex_i, wb_ready_i,
        output ch_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_o, wb_ch_o
    );

endinterface

// File: rtl/flu_wb_merge_fifo.sv
// flu_wb_merge_fifo
// DEPTH-entry FIFO used as one channel buffer of flu_wb_merge. Pointers
// wrap at DEPTH-1 so any depth from 1 upward works, not only powers of two.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        empties the buffer; push/pop in the same cycle are dropped
//   push_i, data_i write an entry (ignored when full)
//   pop_i          remove the head (ignored when empty)
//   data_o         current head entry
//   full_o,empty_o occupancy flags, derived from registered count only
module flu_wb_merge_fifo
    import flu_wb_merge_pkg::*;
#(
    parameter int unsigned DEPTH   = FLU_WB_DEPTH,
    parameter type         entry_t = flu_wb_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   flush_i,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output entry_t data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pushEff;
    logic             popEff;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rptr_q];

    // Pointer and occupancy next-state; flush wins over any push or pop.
    always_comb begin
        pushEff = push_i & ~full_o & ~flush_i;
        popEff  = pop_i & ~empty_o & ~flush_i;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (pushEff) wptr_d = nextPtr(wptr_q);
            if (popEff)  rptr_d = nextPtr(rptr_q);
            case ({pushEff, popEff})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read once counted as valid.
    always_ff @(posedge clk_i) begin
        if (pushEff) mem_q[wptr_q] <= data_i;
    end

    // The parent gates pushes with ready and pops with the grant, so neither
    // should ever reach a full or empty buffer.
    assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
    assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/flu_wb_merge.sv
// flu_wb_merge
// Writeback merge for the fixed-latency issue port. Each of NR_CH functional
// unit channels owns a DEPTH-entry buffer; one buffered result per cycle is
// arbitrated onto the scoreboard write port under valid/ready.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   flush_i       discard every buffered result, clear lock and RR pointer
//   bus (slave)   channel push handshakes and merged writeback port
//   idle_o        all channel buffers empty
// Build option FLU_WB_RR_EN: round-robin arbitration starting at rr_q instead
// of fixed lowest-index priority. Without it no rr_q register exists.
module flu_wb_merge
    import flu_wb_merge_pkg::*;
#(
    parameter int unsigned NR_CH  = FLU_WB_NR_CH,
    parameter int unsigned DATA_W = XLEN,
    parameter int unsigned TID_W  = TRANS_ID_BITS,
    parameter int unsigned DEPTH  = FLU_WB_DEPTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    flu_wb_merge_if.slave bus,
    output logic          idle_o
);

    localparam int unsigned CH_W = idxWidth(NR_CH);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [TID_W-1:0]  trans_id;
        logic              ex;
    } entry_t;

    entry_t [NR_CH-1:0] pushData;
    entry_t [NR_CH-1:0] headData;
    entry_t             selEntry;
    logic   [NR_CH-1:0] pushEn;
    logic   [NR_CH-1:0] popEn;
    logic   [NR_CH-1:0] full;
    logic   [NR_CH-1:0] empty;
    logic   [NR_CH-1:0] chReady;
    logic   [CH_W-1:0]  grantCh;
    logic               wbValid;
    logic               handshake;

    logic               lock_q, lock_d;
    logic   [CH_W-1:0]  lock_ch_q, lock_ch_d;

    // Ready is held low during reset and otherwise depends only on the
    // registered fill level, never on the writeback side.
    assign chReady        = ~full & {NR_CH{~rst_i}};
    assign bus.ch_ready_o = chReady;
    assign pushEn         = bus.ch_valid_i & chReady;
    assign idle_o         = &empty;

    for (genvar c = 0; c < NR_CH; c++) begin : g_ch
        assign pushData[c].result   = bus.ch_result_i[c];
        assign pushData[c].trans_id = bus.ch_trans_id_i[c];
        assign pushData[c].ex       = bus.ch_ex_i[c];
        assign popEn[c]             = handshake & (grantCh == CH_W'(c));

        flu_wb_merge_fifo #(
            .DEPTH   (DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .push_i  (pushEn[c]),
            .data_i  (pushData[c]),
            .pop_i   (popEn[c]),
            .data_o  (headData[c]),
            .full_o  (full[c]),
            .empty_o (empty[c])
        );
    end

`ifdef FLU_WB_RR_EN
    logic [CH_W-1:0] rr_q, rr_d;
    logic [CH_W-1:0] cand;
    logic            found;

    // Round-robin search over non-empty heads starting at rr_q; an active
    // lock overrides the search so the presented head cannot change.
    always_comb begin
        grantCh = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 0; k < int'(NR_CH); k++) begin
            cand = CH_W'((int'(rr_q) + k) % int'(NR_CH));
            if (!found && !empty[cand]) begin
                found   = 1'b1;
                grantCh = cand;
            end
        end
        if (lock_q) grantCh = lock_ch_q;
    end

    // Pointer moves past the winner on every accepted result.
    always_comb begin
        rr_d = rr_q;
        if (handshake) begin
            rr_d = (grantCh == CH_W'(NR_CH - 1)) ? '0 : grantCh + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) rr_q <= '0;
        else                  rr_q <= rr_d;
    end
`else
    // Fixed priority: scanning downward leaves the lowest non-empty index;
    // an active lock overrides it.
    always_comb begin
        grantCh = '0;
        for (int k = int'(NR_CH) - 1; k >= 0; k--) begin
            if (!empty[k]) grantCh = CH_W'(k);
        end
        if (lock_q) grantCh = lock_ch_q;
    end
`endif

    assign wbValid   = lock_q | ~(&empty);
    assign handshake = wbValid & bus.wb_ready_i & ~flush_i;
    assign selEntry  = headData[grantCh];

    assign bus.wb_valid_o    = wbValid;
    assign bus.wb_result_o   = wbValid ? selEntry.result   : '0;
    assign bus.wb_trans_id_o = wbValid ? selEntry.trans_id : '0;
    assign bus.wb_ex_o       = wbValid ? selEntry.ex       : 1'b0;
    assign bus.wb_ch_o       = wbValid ? grantCh           : '0;

    // A stalled result pins the grant until it is accepted, so the
    // scoreboard sees stable outputs even if higher-priority data arrives.
    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (wbValid && !bus.wb_ready_i) begin
            lock_d    = 1'b1;
            lock_ch_d = grantCh;
        end else if (handshake) begin
            lock_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end

endmodule

// File: tb/tb_flu_wb_merge.sv
// tb_flu_wb_merge
// Directed bench for flu_wb_merge (NR_CH=4, DATA_W=64, TID_W=3, DEPTH=2).
// Stimulus pushes the hand-computed writeback sequence into a queue; a
// monitor on the falling edge compares every presented result with the
// queue head and retires it on a handshake.
module tb_flu_wb_merge;
    import flu_wb_merge_pkg::*;

    typedef struct {
        logic [1:0]  ch;
        logic [2:0]  id;
        logic [63:0] result;
        logic        ex;
    } expT;

    logic clock = 1'b0;
    logic reset;
    logic flush;
    logic idle;
    int   checks = 0;
    int   errors = 0;
    int   handshakes = 0;
    int   hsBefore;
    expT  expQ[$];

    always #5 clock = ~clock;

    flu_wb_merge_if #(.NR_CH(4), .DATA_W(64), .TID_W(3)) bus ();

    flu_wb_merge #(
        .NR_CH  (4),
        .DATA_W (64),
        .TID_W  (3),
        .DEPTH  (2)
    ) dut (
        .clk_i   (clock),
        .rst_i   (reset),
        .flush_i (flush),
        .bus     (bus),
        .idle_o  (idle)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic setCh(input int c, input logic [63:0] result,
                         input logic [2:0] id, input logic ex);
        bus.ch_result_i[c]   = result;
        bus.ch_trans_id_i[c] = id;
        bus.ch_ex_i[c]       = ex;
    endtask

    task automatic pushExpect(input logic [1:0] ch, input logic [2:0] id,
                              input logic [63:0] result, input logic ex);
        expT e;
        e.ch = ch; e.id = id; e.result = result; e.ex = ex;
        expQ.push_back(e);
    endtask

    // Drive one cycle of inputs, then return just after the clock edge.
    task automatic applyStimulus(input logic [3:0] valid, input logic wbReady,
                                 input logic doFlush);
        bus.ch_valid_i = valid;
        bus.wb_ready_i = wbReady;
        flush          = doFlush;
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare whatever is presented against the expected head.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.wb_valid_o) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL wb_unexpected: got id %0d result 0x%0h, expected no output",
                             bus.wb_trans_id_o, bus.wb_result_o);
                end else begin
                    checkOutput("wb_ch",     64'(bus.wb_ch_o),       64'(expQ[0].ch));
                    checkOutput("wb_id",     64'(bus.wb_trans_id_o), 64'(expQ[0].id));
                    checkOutput("wb_result", bus.wb_result_o,        expQ[0].result);
                    checkOutput("wb_ex",     64'(bus.wb_ex_o),       64'(expQ[0].ex));
                    if (bus.wb_ready_i && !flush) begin
                        void'(expQ.pop_front());
                        handshakes++;
                    end
                end
            end else begin
                checkOutput("wb_zero_when_idle",
                            bus.wb_result_o | 64'(bus.wb_trans_id_o) | 64'(bus.wb_ex_o) | 64'(bus.wb_ch_o),
                            64'h0);
            end
        end
    end

    initial begin
        reset              = 1'b1;
        flush              = 1'b0;
        bus.ch_valid_i     = '0;
        bus.ch_result_i    = '0;
        bus.ch_trans_id_i  = '0;
        bus.ch_ex_i        = '0;
        bus.wb_ready_i     = 1'b0;

        // Reset values
        #1;
        checkOutput("rst_ch_ready", 64'(bus.ch_ready_o), 64'h0);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_ch_ready_hold", 64'(bus.ch_ready_o), 64'h0);
        checkOutput("rst_wb_valid",      64'(bus.wb_valid_o), 64'h0);
        checkOutput("rst_wb_result",     bus.wb_result_o,     64'h0);
        checkOutput("rst_wb_ch",         64'(bus.wb_ch_o),    64'h0);
        checkOutput("rst_idle",          64'(idle),           64'h1);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_ch_ready", 64'(bus.ch_ready_o), 64'hF);

        // Single push on ch1, one-cycle latency
        setCh(1, 64'hDEAD, 3'd5, 1'b0);
        pushExpect(2'd1, 3'd5, 64'hDEAD, 1'b0);
        applyStimulus(4'b0010, 1'b1, 1'b0);
        checkOutput("single_latency_valid", 64'(bus.wb_valid_o), 64'h1);
        checkOutput("single_idle_busy",     64'(idle),           64'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("single_idle_after_pop", 64'(idle),           64'h1);
        checkOutput("single_valid_after",    64'(bus.wb_valid_o), 64'h0);

        // Contention: all four channels in one cycle, drained in index order
        for (int c = 0; c < 4; c++) begin
            setCh(c, 64'hA5A5_0000_0000_0100 + 64'(c), 3'(c), (c == 3));
            pushExpect(2'(c), 3'(c), 64'hA5A5_0000_0000_0100 + 64'(c), (c == 3));
        end
        applyStimulus(4'b1111, 1'b1, 1'b0);
        repeat (4) applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("contention_drained", 64'(idle), 64'h1);

        // Backpressure lock: ch2 stalls 3 cycles while ch0 arrives
        setCh(2, 64'h2222_0000_0000_0002, 3'd6, 1'b0);
        pushExpect(2'd2, 3'd6, 64'h2222_0000_0000_0002, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        setCh(0, 64'h0000_0000_0000_0BAD, 3'd1, 1'b1);
        pushExpect(2'd0, 3'd1, 64'h0000_0000_0000_0BAD, 1'b1);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("lock_hold_ch", 64'(bus.wb_ch_o), 64'h2);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("lock_drained", 64'(idle), 64'h1);

        // Full and overflow on ch3
        setCh(3, 64'h3333_0000_0000_0001, 3'd4, 1'b0);
        pushExpect(2'd3, 3'd4, 64'h3333_0000_0000_0001, 1'b0);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("full_ready_one_entry", 64'(bus.ch_ready_o[3]), 64'h1);
        setCh(3, 64'h3333_0000_0000_0002, 3'd5, 1'b1);
        pushExpect(2'd3, 3'd5, 64'h3333_0000_0000_0002, 1'b1);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("full_ready_two_entries", 64'(bus.ch_ready_o[3]), 64'h0);
        setCh(3, 64'h3333_0000_0000_0003, 3'd7, 1'b0);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("overflow_ready_still_low", 64'(bus.ch_ready_o[3]), 64'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("overflow_not_stored", 64'(idle), 64'h1);

        // Push attempt and pop in one cycle on full ch0
        setCh(0, 64'h0A, 3'd1, 1'b0);
        pushExpect(2'd0, 3'd1, 64'h0A, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        setCh(0, 64'h0B, 3'd2, 1'b0);
        pushExpect(2'd0, 3'd2, 64'h0B, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("pushpop_full_ready", 64'(bus.ch_ready_o[0]), 64'h0);
        setCh(0, 64'h0C, 3'd3, 1'b0);
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("pushpop_ready_after", 64'(bus.ch_ready_o[0]), 64'h1);
        checkOutput("pushpop_one_left",    64'(idle),              64'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("pushpop_drained", 64'(idle), 64'h1);

        // Flush with five buffered entries, a concurrent push and ready high
        for (int c = 0; c < 4; c++) begin
            setCh(c, 64'hF000 + 64'(c), 3'(c), 1'b0);
            pushExpect(2'(c), 3'(c), 64'hF000 + 64'(c), 1'b0);
        end
        applyStimulus(4'b1111, 1'b0, 1'b0);
        setCh(1, 64'hF011, 3'd7, 1'b0);
        pushExpect(2'd1, 3'd7, 64'hF011, 1'b0);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        hsBefore = handshakes;
        setCh(2, 64'hF022, 3'd2, 1'b1);
        applyStimulus(4'b0100, 1'b1, 1'b1);
        expQ.delete();
        checkOutput("flush_wb_valid", 64'(bus.wb_valid_o), 64'h0);
        checkOutput("flush_idle",     64'(idle),           64'h1);
        checkOutput("flush_ch_ready", 64'(bus.ch_ready_o), 64'hF);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("flush_no_handshake", 64'(handshakes), 64'(hsBefore));

        // Clean operation after flush
        setCh(3, 64'hC0FFEE, 3'd3, 1'b1);
        pushExpect(2'd3, 3'd3, 64'hC0FFEE, 1'b1);
        applyStimulus(4'b1000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("final_idle",        64'(idle),        64'h1);
        checkOutput("final_queue_empty", 64'(expQ.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
